// File: rtl/kernel_run_scheduler_if.sv
// Handshake bundle between the job scheduler and its environment:
// job descriptor channel, kernel start/done port and result record channel.
interface kernel_run_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 4,
    parameter int CNT_WIDTH  = 16
);
    logic                  job_valid;
    logic                  job_ready;
    logic [DATA_WIDTH-1:0] job_alpha;
    logic [DATA_WIDTH-1:0] job_beta;

    logic                  k_ap_start;
    logic                  k_ap_ready;
    logic                  k_ap_done;
    logic [DATA_WIDTH-1:0] k_alpha;
    logic [DATA_WIDTH-1:0] k_beta;

    logic                  res_valid;
    logic                  res_ready;
    logic [ID_WIDTH-1:0]   res_id;
    logic [CNT_WIDTH-1:0]  res_cycles;

    // Scheduler side
    modport slave (
        input  job_valid, job_alpha, job_beta, k_ap_ready, k_ap_done, res_ready,
        output job_ready, k_ap_start, k_alpha, k_beta, res_valid, res_id, res_cycles
    );

    // Job producer / kernel / result consumer side
    modport master (
        output job_valid, job_alpha, job_beta, k_ap_ready, k_ap_done, res_ready,
        input  job_ready, k_ap_start, k_alpha, k_beta, res_valid, res_id, res_cycles
    );
endinterface

// File: rtl/kernel_run_scheduler.sv
// Job-queue controller for one ap_start/ap_ready/ap_done kernel: buffers
// (alpha, beta) jobs, launches them one at a time and reports run lengths.
module kernel_run_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ID_WIDTH   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    kernel_run_scheduler_if.slave      bus,
    output logic [$clog2(DEPTH+1)-1:0] jobs_pending,
    output logic                       busy,
    output logic                       err_spurious_done
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] alpha;
        logic [DATA_WIDTH-1:0] beta;
    } job_t;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

    state_t                state, state_nxt;
    job_t                  mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [ID_WIDTH-1:0]   next_id, cur_id;
    logic [CNT_WIDTH-1:0]  cycles;
    logic [DATA_WIDTH-1:0] k_alpha_q, k_beta_q;
    logic                  res_valid_q;
    logic [ID_WIDTH-1:0]   res_id_q;
    logic [CNT_WIDTH-1:0]  res_cycles_q;
    logic                  push, pop, load, finish;

    // A full FIFO refuses even when a launch frees a slot on the same edge.
    assign bus.job_ready  = rst && (count < CW'(DEPTH));
    assign push           = bus.job_valid && bus.job_ready;

    assign bus.k_ap_start = (state == LAUNCH);
    assign bus.k_alpha    = k_alpha_q;
    assign bus.k_beta     = k_beta_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_cycles = res_cycles_q;
    assign jobs_pending   = count;
    assign busy           = (state != IDLE) || (count != '0);

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred on untaken paths.
        state_nxt = state;
        load      = 1'b0;
        pop       = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0 && !res_valid_q) begin
                    state_nxt = LAUNCH;
                    load      = 1'b1;
                end
            end
            LAUNCH: begin
                if (bus.k_ap_ready) begin
                    state_nxt = RUN;
                    pop       = 1'b1;
                end
            end
            RUN: begin
                if (bus.k_ap_done) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: payload storage is deliberately not reset; occupancy and pointers alone define validity.
        if (push) mem[wr_ptr] <= '{id: next_id, alpha: bus.job_alpha, beta: bus.job_beta};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            next_id <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                next_id <= next_id + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Arguments and id are captured when leaving IDLE and held until the next job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_alpha_q <= '0;
            k_beta_q  <= '0;
            cur_id    <= '0;
            cycles    <= '0;
        end else begin
            if (load) begin
                k_alpha_q <= mem[rd_ptr].alpha;
                k_beta_q  <= mem[rd_ptr].beta;
                cur_id    <= mem[rd_ptr].id;
            end
            if (pop)
                cycles <= CNT_WIDTH'(1);
            else if (state == RUN && !bus.k_ap_done && cycles != '1)
                cycles <= cycles + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_q       <= 1'b0;
            res_id_q          <= '0;
            res_cycles_q      <= '0;
            err_spurious_done <= 1'b0;
        end else begin
            if (finish) begin
                res_valid_q  <= 1'b1;
                res_id_q     <= cur_id;
                res_cycles_q <= cycles;
            end else if (res_valid_q && bus.res_ready) begin
                res_valid_q  <= 1'b0;
            end
            if (bus.k_ap_done && state != RUN) err_spurious_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_kernel_run_scheduler.sv
// Directed bench for kernel_run_scheduler with a behavioural kernel and a
// result scoreboard filled on job acceptance and drained on result handshake.
module tb_kernel_run_scheduler;
    localparam int DW  = 8;
    localparam int DP  = 4;
    localparam int IW  = 4;
    localparam int CWD = 4;

    typedef struct {
        logic [IW-1:0]  id;
        logic [CWD-1:0] cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [2:0]     jobs_pending;
    logic           busy;
    logic           err;
    logic           kready;
    logic           spur;
    logic           model_done;
    int             run_len;
    int             cd;
    int             checks = 0;
    int             errors = 0;
    logic [IW-1:0]  exp_id;
    exp_t           exp_q[$];

    kernel_run_scheduler_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .CNT_WIDTH(CWD)) bus ();

    kernel_run_scheduler #(
        .DATA_WIDTH(DW), .DEPTH(DP), .ID_WIDTH(IW), .CNT_WIDTH(CWD)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .jobs_pending      (jobs_pending),
        .busy              (busy),
        .err_spurious_done (err)
    );

    assign bus.k_ap_ready = kready;
    assign bus.k_ap_done  = model_done | spur;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Kernel: pulses done run_len edges after the edge that samples start && ready.
    initial begin
        cd = 0;
        model_done = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            model_done = 1'b0;
            if (!rst) cd = 0;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) model_done = 1'b1;
            end else if (bus.k_ap_start && kready) cd = run_len;
        end
    end

    // Result monitor: a record is consumed on the edge after valid && ready is seen here.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst && bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) check("res_unexpected", 32'(bus.res_valid), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("res_id", 32'(bus.res_id), 32'(e.id));
                    check("res_cycles", 32'(bus.res_cycles), 32'(e.cyc));
                end
            end
        end
    end

    task automatic push_job(input logic [DW-1:0] a, input logic [DW-1:0] b, output int edges);
        logic acc = 1'b0;
        bus.job_valid = 1'b1;
        bus.job_alpha = a;
        bus.job_beta  = b;
        edges = 0;
        while (!acc && edges < 100) begin
            acc = bus.job_ready;
            @(negedge clk);
            edges++;
        end
        bus.job_valid = 1'b0;
        check("job_accept", 32'(acc), 32'd1);
        if (acc) begin
            exp_q.push_back('{id: exp_id, cyc: (run_len > 15) ? 4'd15 : 4'(run_len)});
            exp_id++;
        end
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy || bus.res_valid || exp_q.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(busy | bus.res_valid), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_res(input int bound);
        int n = 0;
        while (!bus.res_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("res_valid_seen", 32'(bus.res_valid), 32'd1);
    endtask

    initial begin
        int e;
        rst = 1'b0;
        bus.job_valid = 1'b0;
        bus.job_alpha = '0;
        bus.job_beta  = '0;
        bus.res_ready = 1'b1;
        kready = 1'b1;
        spur = 1'b0;
        run_len = 10;
        exp_id = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_job_ready", 32'(bus.job_ready), 32'd0);
        check("rst_start", 32'(bus.k_ap_start), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_pending", 32'(jobs_pending), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_job_ready", 32'(bus.job_ready), 32'd1);

        // Single job: alpha=3, beta=5, done 10 cycles after launch
        push_job(8'd3, 8'd5, e);
        check("s_pending_e0", 32'(jobs_pending), 32'd1);
        check("s_start_e0", 32'(bus.k_ap_start), 32'd0);
        @(negedge clk);
        check("s_start_e1", 32'(bus.k_ap_start), 32'd1);
        check("s_alpha_e1", 32'(bus.k_alpha), 32'd3);
        check("s_beta_e1", 32'(bus.k_beta), 32'd5);
        @(negedge clk);
        check("s_start_e2", 32'(bus.k_ap_start), 32'd0);
        check("s_pending_e2", 32'(jobs_pending), 32'd0);
        repeat (5) begin
            @(negedge clk);
            check("s_alpha_run", 32'(bus.k_alpha), 32'd3);
            check("s_beta_run", 32'(bus.k_beta), 32'd5);
        end
        wait_idle(40);
        check("s_busy_after", 32'(busy), 32'd0);

        // Fill and backpressure with the kernel stalled
        kready = 1'b0;
        run_len = 3;
        for (int i = 0; i < 4; i++) push_job(8'(16 + i), 8'(32 + i), e);
        check("f_pending_full", 32'(jobs_pending), 32'd4);
        check("f_ready_full", 32'(bus.job_ready), 32'd0);
        bus.job_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("f_ready_stall", 32'(bus.job_ready), 32'd0);
            check("f_pending_stall", 32'(jobs_pending), 32'd4);
        end
        kready = 1'b1;
        push_job(8'd20, 8'd36, e);
        check("f_fifth_edges", 32'(e), 32'd2);
        check("f_pending_after", 32'(jobs_pending), 32'd4);
        wait_idle(200);

        // Result backpressure
        bus.res_ready = 1'b0;
        run_len = 4;
        push_job(8'd7, 8'd9, e);
        push_job(8'd8, 8'd10, e);
        wait_res(50);
        repeat (20) begin
            @(negedge clk);
            check("b_no_start", 32'(bus.k_ap_start), 32'd0);
            check("b_valid_held", 32'(bus.res_valid), 32'd1);
            check("b_id_stable", 32'(bus.res_id), 32'd6);
            check("b_cycles_stable", 32'(bus.res_cycles), 32'd4);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("b_valid_drop", 32'(bus.res_valid), 32'd0);
        check("b_start_h0", 32'(bus.k_ap_start), 32'd0);
        @(negedge clk);
        check("b_start_h1", 32'(bus.k_ap_start), 32'd1);
        @(negedge clk);
        check("b_start_h2", 32'(bus.k_ap_start), 32'd0);
        wait_idle(50);

        // Spurious done in IDLE
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        check("sp_err_set", 32'(err), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("sp_no_result", 32'(bus.res_valid), 32'd0);
            check("sp_idle", 32'(busy), 32'd0);
        end
        run_len = 6;
        push_job(8'd1, 8'd2, e);
        wait_idle(50);
        check("sp_err_sticky", 32'(err), 32'd1);

        // Reset during RUN with two jobs queued
        run_len = 30;
        for (int i = 0; i < 3; i++) push_job(8'(64 + i), 8'(80 + i), e);
        check("r_pending_before", 32'(jobs_pending), 32'd2);
        check("r_in_run", 32'(bus.k_ap_start), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("r_job_ready", 32'(bus.job_ready), 32'd0);
        check("r_start", 32'(bus.k_ap_start), 32'd0);
        check("r_alpha", 32'(bus.k_alpha), 32'd0);
        check("r_beta", 32'(bus.k_beta), 32'd0);
        check("r_res_valid", 32'(bus.res_valid), 32'd0);
        check("r_res_id", 32'(bus.res_id), 32'd0);
        check("r_res_cycles", 32'(bus.res_cycles), 32'd0);
        check("r_pending", 32'(jobs_pending), 32'd0);
        check("r_busy", 32'(busy), 32'd0);
        check("r_err", 32'(err), 32'd0);
        exp_q.delete();
        exp_id = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Id wrap and counter saturation: 17 jobs, ids 0..15 then 0, cycles capped at 15
        run_len = 20;
        for (int i = 0; i < 17; i++) push_job(8'(i), 8'(255 - i), e);
        wait_idle(800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kernel_run_scheduler.md
# kernel_run_scheduler

Job-queue controller that sits in front of one handshake kernel wrapper, such as the 2mm top with its `ap_start`/`ap_ready`/`ap_done` ports. It accepts job descriptors (alpha, beta) over a valid/ready channel and buffers them in a small FIFO. It launches the kernel once per job, holding the arguments stable, and times each run. For each completed run it emits a result record (job id, cycle count) on a second valid/ready channel.

## Interface
- DATA_WIDTH, 8, width of alpha/beta arguments
- DEPTH, 4, job FIFO entries; power of two, >= 2
- ID_WIDTH, 4, job id width; ids wrap modulo 2^ID_WIDTH
- CNT_WIDTH, 16, run cycle counter width; saturating
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- job_valid  in  1  job descriptor valid
- job_ready  out  1  FIFO can accept a job
- job_alpha  in  DATA_WIDTH  job alpha argument
- job_beta  in  DATA_WIDTH  job beta argument
- k_ap_start  out  1  kernel start request
- k_ap_ready  in  1  kernel idle; it samples start and arguments on this edge
- k_ap_done  in  1  kernel completion, one-cycle pulse
- k_alpha  out  DATA_WIDTH  argument to kernel, registered
- k_beta  out  DATA_WIDTH  argument to kernel, registered
- res_valid  out  1  result record valid
- res_ready  in  1  result consumer ready
- res_id  out  ID_WIDTH  id of the completed job
- res_cycles  out  CNT_WIDTH  run length in cycles
- jobs_pending  out  $clog2(DEPTH+1)  FIFO occupancy
- busy  out  1  FSM not IDLE or FIFO non-empty
- err_spurious_done  out  1  sticky flag: k_ap_done seen outside RUN

## Operation
- **FIFO.** Each entry holds {id, alpha, beta}.
  - job_ready = (count < DEPTH). A full FIFO never accepts, even if a pop occurs in the same cycle; there is no pass-through.
  - Push on job_valid && job_ready. The entry gets id = next_id, then next_id increments, wrapping 2^ID_WIDTH-1 to 0.
  - Pop only on the launch edge. A push and a pop on the same edge leave count unchanged.
- **FSM states:** IDLE, LAUNCH, RUN.
  - IDLE -> LAUNCH when count > 0 and res_valid == 0. On this edge, k_alpha/k_beta/cur_id are loaded from the FIFO head.
  - LAUNCH: k_ap_start = 1, decoded from state. On an edge with k_ap_ready == 1: pop FIFO, set cycle counter = 1, go to RUN. Otherwise stay in LAUNCH with arguments held.
  - RUN: k_ap_start = 0.
    - If k_ap_done == 1: res_id <= cur_id, res_cycles <= counter, res_valid <= 1, go to IDLE.
    - Otherwise counter <= counter + 1, saturating at 2^CNT_WIDTH-1.
- **Result register.** Single entry. res_valid clears on res_valid && res_ready. res_id and res_cycles are stable while res_valid && !res_ready.
- **Argument hold.** k_alpha/k_beta change only on the IDLE->LAUNCH edge and hold through RUN.
- **Spurious done.** k_ap_done == 1 in IDLE or LAUNCH sets err_spurious_done. The pulse is otherwise ignored and does not change state. The flag clears only on reset.
- **Reset.** Asserting rst (low) at any time, including mid-run, does the following:
  - FSM -> IDLE.
  - FIFO emptied; next_id = 0; counter = 0.
  - All outputs 0: job_ready = 0 while rst is low and 1 after release, since count = 0.
  - The kernel itself is not aborted; the system resets it with the same reset.

## Timing
- Job accepted at edge E0 → jobs_pending = 1 after E0. IDLE->LAUNCH at E1; k_ap_start is high in the cycle after E1.
- With k_ap_ready already high, the launch edge is E2. There are 2 edges minimum from job accept to launch.
- A done sampled at edge Ed → res_valid is high after Ed.
- res_cycles = number of RUN cycles up to and including the cycle in which done is sampled. A done in the first RUN cycle gives 1.
- Back-to-back jobs: the next IDLE->LAUNCH needs res_valid == 0.
  - With res_ready held high, res_valid drops one edge after rising.
  - The next launch edge is then 3 edges after the done edge.
- All outputs are registered or decoded from registered state. There are no combinational input-to-output paths except job_ready, which depends on count only.

## Test plan
- **Single job.** Push alpha=3, beta=5; kernel model is ready and pulses done 10 cycles after the launch edge.
  - Expect k_alpha=3 and k_beta=5, held through RUN.
  - Expect res_id=0 and res_cycles=10.
  - Expect busy=0 afterwards.
- **Fill and backpressure.** Push 5 jobs back-to-back while the kernel is stalled (k_ap_ready=0).
  - job_ready drops after 4 accepts; jobs_pending=4.
  - 5th job accepted only after the first launch edge.
- **Result backpressure.** Hold res_ready=0 for 20 cycles after the first done.
  - No second k_ap_start while res_valid=1.
  - res_id and res_cycles stable.
  - Launch resumes 2 edges after the res handshake.
- **Id wrap and counter saturation.** Run 17 jobs; res_id sequence is 0..15, 0.
  - With CNT_WIDTH=4 and done after 20 cycles, res_cycles=15.
- **Spurious done.** Pulse k_ap_done in IDLE → err_spurious_done=1, no result emitted. The next job still completes normally.
- **Reset mid-RUN.** Drive rst low during RUN with 2 jobs queued.
  - All outputs 0, jobs_pending=0.
  - After release, a new job gets id 0.
